pcileech_bar_rd_initiator: RTL and testbench



---
 rtl/pcileech_bar_pkg.sv | 43 ++++
 rtl/pcileech_bar_cpl_fifo.sv | 64 ++++++
 rtl/pcileech_bar_rd_initiator.sv | 208 ++++++++++++++++++++
 tb/tb_pcileech_bar_rd_initiator.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcileech_bar_pkg.sv
// ============================================================================
// Module   : pcileech_bar_pkg
// Purpose  : Shared types and constants for the BAR read initiator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pcileech_bar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ERR   = 2'd3
  } bar_rd_state_t;

  localparam int CTX_W          = 88;
  localparam int CTX_LAST       = 0;
  localparam int CTX_IDX_LO     = 1;
  localparam int CTX_IDX_HI     = 10;
  localparam int CTX_GEN        = 11;
  localparam int RD_CREDITS     = 4;
  localparam int CPL_FIFO_DEPTH = 4;

  typedef struct packed {
    logic [31:0]      data;
    logic [CTX_W-1:0] ctx;
    logic             last;
    logic             err;
  } cpl_beat_t;

  function automatic logic [CTX_W-1:0] rd_ctx_pack(
    input logic [CTX_W-1:CTX_GEN+1]       hi,
    input logic                           gen,
    input logic [CTX_IDX_HI:CTX_IDX_LO]   idx,
    input logic                           last
  );
    return {hi, gen, idx, last};
  endfunction

endpackage

`default_nettype wire

// File: rtl/pcileech_bar_cpl_fifo.sv
// ============================================================================
// Module   : pcileech_bar_cpl_fifo
// Purpose  : 4-entry first-word-fall-through completion beat FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pcileech_bar_cpl_fifo
  import pcileech_bar_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  cpl_beat_t din,
  input  logic      pop,
  output cpl_beat_t dout,
  output logic      full,
  output logic      empty,
  output logic [2:0] count
);

  cpl_beat_t  r_mem [CPL_FIFO_DEPTH];
  logic [1:0] r_wr_ptr;
  logic [1:0] r_rd_ptr;
  logic [2:0] r_count;
  logic       w_push;
  logic       w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage is reset too so the completion outputs read zero during reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CPL_FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign full  = (r_count == 3'd4);
  assign empty = (r_count == 3'd0);
  assign count = r_count;
  assign dout  = r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/pcileech_bar_rd_initiator.sv
// ============================================================================
// Module   : pcileech_bar_rd_initiator
// Purpose  : Splits a multi-DW BAR read into per-DW reads and returns beats.
//            Optional response timeout: PCILEECH_BAR_RDINIT_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pcileech_bar_rd_initiator
  import pcileech_bar_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [9:0]        req_len_dw,
  input  logic [CTX_W-1:0]  req_ctx,
  output logic [CTX_W-1:0]  rd_req_ctx,
  output logic [31:0]       rd_req_addr,
  output logic              rd_req_valid,
  input  logic [CTX_W-1:0]  rd_rsp_ctx,
  input  logic [31:0]       rd_rsp_data,
  input  logic              rd_rsp_valid,
  output logic              cpl_valid,
  input  logic              cpl_ready,
  output logic [31:0]       cpl_data,
  output logic [CTX_W-1:0]  cpl_ctx,
  output logic              cpl_last,
  output logic              cpl_err
);

  bar_rd_state_t              r_state;
  bar_rd_state_t              w_state_nxt;
  logic                       r_rst_done;
  logic [29:0]                r_base;
  logic [CTX_W-1:CTX_GEN+1]   r_ctx_hi;
  logic [9:0]                 r_last_idx;
  logic [9:0]                 r_idx;
  logic [2:0]                 r_outstanding;

  logic                       w_gen;
  logic                       w_timeout;
  logic                       w_req_fire;
  logic [3:0]                 w_in_flight;
  logic                       w_issue;
  logic                       w_issue_last;
  logic                       w_rsp_acc;
  logic                       w_rsp_last;
  logic                       w_err_push;
  logic                       w_fifo_push;
  logic                       w_fifo_full;
  logic                       w_fifo_empty;
  logic [2:0]                 w_fifo_count;
  cpl_beat_t                  w_fifo_din;
  cpl_beat_t                  w_fifo_dout;
  logic [13:0]                w_unused_req;

  assign w_unused_req = {req_ctx[CTX_GEN:0], req_addr[1:0]};

  assign req_ready    = (r_state == ST_IDLE) && r_rst_done;
  assign w_req_fire   = req_valid && req_ready;
  // Credits cover both in-flight reads and FIFO slots, so a reply always has room.
  assign w_in_flight  = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
  assign w_issue      = (r_state == ST_ISSUE) && (w_in_flight < 4'(RD_CREDITS));
  assign w_issue_last = w_issue && (r_idx == r_last_idx);
  assign w_rsp_acc    = rd_rsp_valid && (rd_rsp_ctx[CTX_GEN] == w_gen) &&
                        (r_outstanding != 3'd0);
  assign w_rsp_last   = w_rsp_acc && rd_rsp_ctx[CTX_LAST];
  assign w_err_push   = (r_state == ST_ERR) && !w_fifo_full;

`ifdef PCILEECH_BAR_RDINIT_TIMEOUT_EN
  localparam logic [15:0] c_tmo_last = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_tmo_cnt;
  logic        r_gen;
  logic        w_tmo_run;

  assign w_tmo_run = ((r_state == ST_ISSUE) || (r_state == ST_DRAIN)) &&
                     (r_outstanding != 3'd0);
  assign w_timeout = w_tmo_run && !w_issue && !w_rsp_acc && (r_tmo_cnt == c_tmo_last);
  assign w_gen     = r_gen;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo_cnt <= 16'd0;
      r_gen     <= 1'b0;
    end else begin
      if (w_timeout || !w_tmo_run || w_issue || w_rsp_acc) begin
        r_tmo_cnt <= 16'd0;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + 16'd1;
      end
      if (w_timeout) begin
        r_gen <= ~r_gen;
      end
    end
  end

  assign cpl_err = w_fifo_dout.err;
`else
  logic [15:0] w_unused_tmo_cfg;
  logic        w_unused_err;

  assign w_unused_tmo_cfg = 16'(TIMEOUT_CYCLES);
  assign w_unused_err     = w_fifo_dout.err;
  assign w_timeout        = 1'b0;
  assign w_gen            = 1'b0;
  assign cpl_err          = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req_fire) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (w_timeout)         w_state_nxt = ST_ERR;
        else if (w_issue_last) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_timeout)       w_state_nxt = ST_ERR;
        else if (w_rsp_last) w_state_nxt = ST_IDLE;
      end
      ST_ERR: begin
        if (w_err_push) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_rst_done    <= 1'b0;
      r_base        <= 30'd0;
      r_ctx_hi      <= '0;
      r_last_idx    <= 10'd0;
      r_idx         <= 10'd0;
      r_outstanding <= 3'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_rst_done <= 1'b1;
      if (w_req_fire) begin
        r_base     <= req_addr[31:2];
        r_ctx_hi   <= req_ctx[CTX_W-1:CTX_GEN+1];
        r_last_idx <= req_len_dw - 10'd1;   // length 0 wraps to index 1023
        r_idx      <= 10'd0;
      end else if (w_issue) begin
        r_idx <= r_idx + 10'd1;
      end
      if (w_timeout) begin
        r_outstanding <= 3'd0;
      end else begin
        case ({w_issue, w_rsp_acc})
          2'b10:   r_outstanding <= r_outstanding + 3'd1;
          2'b01:   r_outstanding <= r_outstanding - 3'd1;
          default: r_outstanding <= r_outstanding;
        endcase
      end
    end
  end

  assign rd_req_valid = w_issue;
  assign rd_req_addr  = w_issue ? ({r_base, 2'b00} + {20'd0, r_idx, 2'b00}) : 32'd0;
  assign rd_req_ctx   = w_issue ? rd_ctx_pack(r_ctx_hi, w_gen, r_idx, (r_idx == r_last_idx))
                                : '0;

  // Only one source can push per cycle: outstanding is zero while in ERR.
  assign w_fifo_push = w_rsp_acc || w_err_push;

  always_comb begin
    w_fifo_din = '0;
    if (r_state == ST_ERR) begin
      w_fifo_din.data = 32'hFFFF_FFFF;
      w_fifo_din.ctx  = rd_ctx_pack(r_ctx_hi, w_gen, r_last_idx, 1'b1);
      w_fifo_din.last = 1'b1;
      w_fifo_din.err  = 1'b1;
    end else begin
      w_fifo_din.data = rd_rsp_data;
      w_fifo_din.ctx  = rd_rsp_ctx;
      w_fifo_din.last = rd_rsp_ctx[CTX_LAST];
      w_fifo_din.err  = 1'b0;
    end
  end

  pcileech_bar_cpl_fifo u_cpl_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_fifo_push),
    .din   (w_fifo_din),
    .pop   (cpl_valid && cpl_ready),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (w_fifo_count)
  );

  assign cpl_valid = !w_fifo_empty;
  assign cpl_data  = w_fifo_dout.data;
  assign cpl_ctx   = w_fifo_dout.ctx;
  assign cpl_last  = w_fifo_dout.last;

endmodule

`default_nettype wire

// File: tb/tb_pcileech_bar_rd_initiator.sv
// ============================================================================
// Module   : tb_pcileech_bar_rd_initiator
// Purpose  : Directed self-checking bench with a fixed-latency (2) BAR model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pcileech_bar_rd_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [9:0]  req_len_dw = '0;
  logic [87:0] req_ctx = '0;
  logic [87:0] rd_req_ctx;
  logic [31:0] rd_req_addr;
  logic        rd_req_valid;
  logic [87:0] rd_rsp_ctx;
  logic [31:0] rd_rsp_data;
  logic        rd_rsp_valid;
  logic        cpl_valid;
  logic        cpl_ready = 1'b1;
  logic [31:0] cpl_data;
  logic [87:0] cpl_ctx;
  logic        cpl_last;
  logic        cpl_err;

  logic        bar_silent = 1'b0;
  logic        inj_valid = 1'b0;
  logic [87:0] inj_ctx = '0;
  logic [31:0] inj_data = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pcileech_bar_rd_initiator #(.TIMEOUT_CYCLES(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_len_dw   (req_len_dw),
    .req_ctx      (req_ctx),
    .rd_req_ctx   (rd_req_ctx),
    .rd_req_addr  (rd_req_addr),
    .rd_req_valid (rd_req_valid),
    .rd_rsp_ctx   (rd_rsp_ctx),
    .rd_rsp_data  (rd_rsp_data),
    .rd_rsp_valid (rd_rsp_valid),
    .cpl_valid    (cpl_valid),
    .cpl_ready    (cpl_ready),
    .cpl_data     (cpl_data),
    .cpl_ctx      (cpl_ctx),
    .cpl_last     (cpl_last),
    .cpl_err      (cpl_err)
  );

  // BAR model: two-cycle pipeline echoing ctx, data = addr ^ 0x5A5A5A5A
  logic        p1_v = 1'b0, p2_v = 1'b0;
  logic [31:0] p1_a = '0,   p2_a = '0;
  logic [87:0] p1_c = '0,   p2_c = '0;

  always @(posedge clk) begin
    p1_v <= rd_req_valid;
    p1_a <= rd_req_addr;
    p1_c <= rd_req_ctx;
    p2_v <= p1_v;
    p2_a <= p1_a;
    p2_c <= p1_c;
  end

  assign rd_rsp_valid = inj_valid | (p2_v & ~bar_silent);
  assign rd_rsp_ctx   = inj_valid ? inj_ctx  : p2_c;
  assign rd_rsp_data  = inj_valid ? inj_data : (p2_a ^ 32'h5A5A_5A5A);

  // Monitor on the falling edge
  int          cyc = 0;
  int          ready_rise_cyc = -1;
  logic        ready_q = 1'b0;
  logic [31:0] iss_addr[$];
  logic [87:0] iss_ctx[$];
  int          iss_cyc[$];
  logic [31:0] beat_data[$];
  logic [87:0] beat_ctx[$];
  logic        beat_last[$];
  logic        beat_err[$];
  int          beat_cyc[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      if (rd_req_valid) begin
        iss_addr.push_back(rd_req_addr);
        iss_ctx.push_back(rd_req_ctx);
        iss_cyc.push_back(cyc);
      end
      if (cpl_valid && cpl_ready) begin
        beat_data.push_back(cpl_data);
        beat_ctx.push_back(cpl_ctx);
        beat_last.push_back(cpl_last);
        beat_err.push_back(cpl_err);
        beat_cyc.push_back(cyc);
      end
      if (req_ready && !ready_q) ready_rise_cyc <= cyc;
    end
    ready_q <= req_ready;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [87:0] exp_ctx(input logic [87:0] rq, input int idx,
                                          input logic last, input logic gen);
    return {rq[87:12], gen, 10'(idx), last};
  endfunction

  task automatic clear_logs();
    iss_addr.delete();  iss_ctx.delete();  iss_cyc.delete();
    beat_data.delete(); beat_ctx.delete(); beat_last.delete();
    beat_err.delete();  beat_cyc.delete();
  endtask

  task automatic send_req(input logic [31:0] a, input logic [9:0] l, input logic [87:0] c);
    int k = 0;
    @(negedge clk);
    while (!req_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("req_ready_wait", req_ready, 1'b1);
    req_valid  = 1'b1;
    req_addr   = a;
    req_len_dw = l;
    req_ctx    = c;
    @(negedge clk);
    req_valid  = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget, input string tag);
    int k = 0;
    while (beat_data.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_beat_count"}, beat_data.size(), n);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1'b0);
    check({tag, "_rd_req_valid"}, rd_req_valid, 1'b0);
    check({tag, "_rd_req_addr"}, rd_req_addr, 32'd0);
    check({tag, "_rd_req_ctx"}, rd_req_ctx, 88'd0);
    check({tag, "_cpl_valid"}, cpl_valid, 1'b0);
    check({tag, "_cpl_data"}, cpl_data, 32'd0);
    check({tag, "_cpl_ctx"}, cpl_ctx, 88'd0);
    check({tag, "_cpl_last_err"}, {cpl_last, cpl_err}, 2'b00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [87:0] c1;
    logic [87:0] c2;
    int errs;
    c1 = 88'h0123456789ABCDEF012FFF;
    c2 = 88'hFEDCBA9876543210FED000;

    // Reset state and release
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b1;
    #1 check("rdy_before_first_clk", req_ready, 1'b0);
    @(negedge clk);
    check("rdy_after_first_clk", req_ready, 1'b1);

    // Single DW, latency 2
    clear_logs();
    send_req(32'h0000_0010, 10'd1, c1);
    wait_beats(1, 50, "t1");
    check("t1_issue_count", iss_addr.size(), 1);
    check("t1_rd_addr", iss_addr[0], 32'h0000_0010);
    check("t1_rd_ctx", iss_ctx[0], exp_ctx(c1, 0, 1'b1, 1'b0));
    check("t1_data", beat_data[0], 32'h5A5A_5A4A);
    check("t1_cpl_ctx", beat_ctx[0], exp_ctx(c1, 0, 1'b1, 1'b0));
    check("t1_last_err", {beat_last[0], beat_err[0]}, 2'b10);
    check("t1_issue_to_beat", beat_cyc[0] - iss_cyc[0], 3);
    check("t1_ready_with_beat", ready_rise_cyc, beat_cyc[0]);

    // Eight DW with completion back-pressure
    clear_logs();
    cpl_ready = 1'b0;
    send_req(32'h0000_0100, 10'd8, c2);
    repeat (20) @(negedge clk);
    check("t2_stall_issues", iss_addr.size(), 4);
    check("t2_stall_addr3", iss_addr[3], 32'h0000_010C);
    check("t2_stall_beats", beat_data.size(), 0);
    check("t2_stall_cpl_valid", cpl_valid, 1'b1);
    cpl_ready = 1'b1;
    wait_beats(8, 200, "t2");
    check("t2_issue_count", iss_addr.size(), 8);
    check("t2_addr7", iss_addr[7], 32'h0000_011C);
    errs = 0;
    for (int k = 0; k < 8; k++) begin
      if (beat_data[k] !== ((32'h100 + 32'(4 * k)) ^ 32'h5A5A_5A5A)) errs++;
      if (beat_last[k] !== (k == 7)) errs++;
      if (beat_ctx[k] !== exp_ctx(c2, k, (k == 7), 1'b0)) errs++;
      if (beat_err[k] !== 1'b0) errs++;
    end
    check("t2_beat_contents", errs, 0);

    // Address wrap, low address bits ignored
    clear_logs();
    send_req(32'hFFFF_FFFF, 10'd2, c1);
    wait_beats(2, 50, "t3");
    check("t3_addr0", iss_addr[0], 32'hFFFF_FFFC);
    check("t3_addr1", iss_addr[1], 32'h0000_0000);
    check("t3_data1", beat_data[1], 32'h5A5A_5A5A);
    check("t3_last", {beat_last[0], beat_last[1]}, 2'b01);

    // Length 0 means 1024 DW
    clear_logs();
    send_req(32'h0000_2000, 10'd0, c2);
    wait_beats(1024, 6000, "t4");
    check("t4_issue_count", iss_addr.size(), 1024);
    errs = 0;
    for (int k = 0; k < 1024; k++) begin
      if (iss_ctx[k][10:1] !== 10'(k)) errs++;
      if (iss_ctx[k][0] !== (k == 1023)) errs++;
      if (iss_addr[k] !== 32'h2000 + 32'(4 * k)) errs++;
    end
    check("t4_issue_seq", errs, 0);
    check("t4_final_last", {iss_ctx[1023][0], beat_last[1023]}, 2'b11);

`ifdef PCILEECH_BAR_RDINIT_TIMEOUT_EN
    // Silent BAR: error beat after the timeout, then generation filtering
    clear_logs();
    bar_silent = 1'b1;
    send_req(32'h0000_0040, 10'd2, c1);
    wait_beats(1, 300, "t5");
    check("t5_err_data", beat_data[0], 32'hFFFF_FFFF);
    check("t5_err_last_err", {beat_last[0], beat_err[0]}, 2'b11);
    check("t5_tmo_latency_64", (beat_cyc[0] - iss_cyc[1] >= 64) && (beat_cyc[0] - iss_cyc[1] <= 66), 1'b1);
    @(negedge clk);
    check("t5_idle_after_err", req_ready, 1'b1);
    clear_logs();
    send_req(32'h0000_0080, 10'd1, c1);
    @(negedge clk);
    check("t5_new_gen", iss_ctx[0][11], 1'b1);
    inj_valid = 1'b1;
    inj_data  = 32'hDEAD_0000;
    inj_ctx   = exp_ctx(c1, 0, 1'b1, 1'b0);
    @(negedge clk);
    inj_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_stale_dropped", beat_data.size(), 0);
    inj_valid = 1'b1;
    inj_data  = 32'hCAFE_0001;
    inj_ctx   = exp_ctx(c1, 0, 1'b1, 1'b1);
    @(negedge clk);
    inj_valid = 1'b0;
    wait_beats(1, 20, "t5_cur");
    check("t5_cur_data", beat_data[0], 32'hCAFE_0001);
    check("t5_cur_last_err", {beat_last[0], beat_err[0]}, 2'b10);
    bar_silent = 1'b0;
`else
    // Silent BAR: stall in DRAIN, recover by reset, stray reply ignored
    clear_logs();
    bar_silent = 1'b1;
    send_req(32'h0000_0040, 10'd2, c1);
    repeat (200) @(negedge clk);
    check("t5_stall_issues", iss_addr.size(), 2);
    check("t5_stall_beats", beat_data.size(), 0);
    check("t5_stall_not_ready", req_ready, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_ready_after_rst", req_ready, 1'b1);
    inj_valid = 1'b1;
    inj_data  = 32'hDEAD_0000;
    inj_ctx   = exp_ctx(c1, 1, 1'b1, 1'b0);
    @(negedge clk);
    inj_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("t5_stray_ignored", beat_data.size(), 0);
    bar_silent = 1'b0;
`endif

    // Reset in the middle of an 8-DW issue burst
    clear_logs();
    send_req(32'h0000_0300, 10'd8, c2);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_reset_outputs("t6_mid");
    check("t6_issued_before_rst", iss_addr.size(), 2);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    check("t6_no_beats", beat_data.size(), 0);
    clear_logs();
    send_req(32'h0000_0500, 10'd2, c1);
    wait_beats(2, 50, "t6_next");
    check("t6_next_ctx", iss_ctx[0], exp_ctx(c1, 0, 1'b0, 1'b0));
    check("t6_next_data0", beat_data[0], 32'h5A5A_5F5A);
    check("t6_next_data1", beat_data[1], 32'h5A5A_5F5E);
    check("t6_next_last", {beat_last[0], beat_last[1]}, 2'b01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
